// File: rtl/sequenciador_musica.sv
// Song sequencer: walks a song memory word by word, playing each note
// for (tempo+1) tempo units of M clock cycles, with pause and abort.
module sequenciador_musica #(
  parameter int M = 12500000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       iniciar,
  input  logic       pausar,
  input  logic       parar,
  input  logic [3:0] musica_in,
  input  logic [3:0] nota_in,
  input  logic [3:0] tempo_in,
  input  logic       fim_musica,
  output logic [4:0] addr,
  output logic [3:0] musica,
  output logic [3:0] nota_out,
  output logic       soando,
  output logic       pronto,
  output logic       fim
);

  localparam int CW = $clog2(M);
  localparam logic [CW-1:0] CMAX = CW'(M - 1);

  typedef enum logic [2:0] {
    OCIOSO, BUSCA, CARREGA, TOCA, PAUSA, FIM
  } estado_t;

  estado_t       estado, prox;
  logic [4:0]    unid;
  logic [3:0]    dur;
  logic [CW-1:0] ciclo;
  logic          conta;
  logic          acabou;
  logic          tocando;

  assign tocando = (estado == TOCA) || (estado == PAUSA);
  // A cycle counts when pausar is low, including the PAUSA exit cycle,
  // so a pause adds exactly as many cycles as pausar was high.
  assign conta  = tocando && !pausar && !parar;
  assign acabou = conta && (ciclo == CMAX) && (unid == {1'b0, dur});

  always_comb begin
    prox = estado;
    unique case (estado)
      OCIOSO:  if (iniciar && !parar) prox = BUSCA;
      BUSCA:   prox = parar ? FIM : CARREGA;
      CARREGA: prox = (parar || fim_musica) ? FIM : TOCA;
      TOCA, PAUSA: begin
        if (parar)       prox = FIM;
        else if (pausar) prox = PAUSA;
        else if (acabou) prox = (addr == 5'd31) ? FIM : BUSCA;
        else             prox = TOCA;
      end
      FIM:     prox = OCIOSO;
      default: prox = OCIOSO;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      estado   <= OCIOSO;
      addr     <= '0;
      musica   <= '0;
      nota_out <= '0;
      dur      <= '0;
      unid     <= '0;
      ciclo    <= '0;
    end else begin
      estado <= prox;
      if (estado == OCIOSO && prox == BUSCA) begin
        addr   <= '0;
        musica <= musica_in;
      end
      if (estado == CARREGA && prox == TOCA) begin
        nota_out <= nota_in;
        dur      <= tempo_in;
        unid     <= '0;
        ciclo    <= '0;
      end
      if (conta) begin
        if (ciclo == CMAX) begin
          ciclo <= '0;
          if (!acabou) unid <= unid + 5'd1;
        end else begin
          ciclo <= ciclo + 1'b1;
        end
      end
      if (tocando && prox == BUSCA) addr <= addr + 5'd1;
      if (estado != OCIOSO && prox == OCIOSO) nota_out <= '0;
    end
  end

  assign soando = (estado == TOCA) && (nota_out != 4'd0);
  assign pronto = (estado == OCIOSO);
  assign fim    = (estado == FIM);

endmodule

// File: doc/sequenciador_musica.md
SEQUENCIADOR_MUSICA -- requirements
Module: sequenciador_musica

Interface
REQ-001 Parameter M, default 12500000, clock cycles per tempo unit (250 ms at 50 MHz); SHALL be >= 2.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 iniciar  input  1  start request, sampled in OCIOSO only.
REQ-005 pausar  input  1  level; high freezes playback.
REQ-006 parar  input  1  abort request, sampled in every state.
REQ-007 musica_in  input  4  song selector, latched on accepted start.
REQ-008 nota_in  input  4  note word from the song memory, valid one cycle after addr changes.
REQ-009 tempo_in  input  4  duration word from the song memory, same timing as nota_in.
REQ-010 fim_musica  input  1  end marker from the song memory, same timing as nota_in.
REQ-011 addr  output  5  song memory address.
REQ-012 musica  output  4  latched song selector driving the memory.
REQ-013 nota_out  output  4  note currently playing.
REQ-014 soando  output  1  high while an audible note sounds.
REQ-015 pronto  output  1  high in OCIOSO.
REQ-016 fim  output  1  one-cycle pulse at song completion or abort.

Function
REQ-017 FSM states SHALL be OCIOSO, BUSCA, CARREGA, TOCA, PAUSA, FIM.
REQ-018 OCIOSO: iniciar=1 -> BUSCA; addr<=0; musica<=musica_in; otherwise remain.
REQ-019 BUSCA: SHALL last exactly one cycle (memory read latency) -> CARREGA.
REQ-020 CARREGA: fim_musica=1 -> FIM; otherwise nota_out<=nota_in, duration register<=tempo_in, unit counter and cycle counter cleared -> TOCA.
REQ-021 TOCA: note duration SHALL be (tempo+1)*M cycles, tempo 0..15 giving 1..16 units; unit counter 5 bits, cycle counter ceil(log2 M) bits.
REQ-022 TOCA completion: addr=31 -> FIM (no wrap); otherwise addr<=addr+1 -> BUSCA.
REQ-023 TOCA with pausar=1 -> PAUSA; counters SHALL freeze; PAUSA with pausar=0 -> TOCA, resuming the count with no lost or extra cycle.
REQ-024 soando SHALL be 1 only in TOCA with nota_out!=0; nota 0 with nonzero tempo is a rest of full duration.
REQ-025 nota_out SHALL hold its last value through BUSCA, CARREGA and PAUSA, and SHALL clear to 0 on entering OCIOSO.
REQ-026 FIM: fim=1 for exactly one cycle -> OCIOSO.
REQ-027 parar=1 in any state other than OCIOSO and FIM -> FIM (fim pulses); parar SHALL take priority over pausar, completion and fim_musica.
REQ-028 iniciar and parar both high in OCIOSO: parar SHALL win; remain in OCIOSO, no pulse.
REQ-029 iniciar outside OCIOSO SHALL be ignored; musica SHALL NOT change mid-song.
REQ-030 musica SHALL retain its value after song end until the next accepted start.

Reset
REQ-031 reset=1 SHALL, on the next edge, force OCIOSO with addr=0, musica=0, nota_out=0, soando=0, fim=0, pronto=1, and all counters at 0.
REQ-032 reset SHALL override all other inputs in every state, including mid-note and PAUSA, with no fim pulse.

Verification (M=4)
REQ-033 Start musica_in=3, word0 nota=5/tempo=1, word1 end -> musica=3; soando high for 8 cycles; then addr=1, fim pulses once; pronto high on the next cycle.
REQ-034 Word0 nota=0/tempo=2 -> soando low for the entire 12-cycle rest; addr then advances to 1.
REQ-035 Pausar held for 5 cycles mid-note (tempo=0) -> note time extends by exactly 5 cycles; soando low during pause.
REQ-036 All 32 words valid, tempo=0 -> addr walks 0..31; fim follows the last note with no wrap to 0.
REQ-037 Parar asserted in TOCA -> fim pulses once, then OCIOSO; iniciar+parar together in OCIOSO -> no start.
REQ-038 Reset mid-PAUSA -> all outputs reach reset values on the next edge; no fim pulse.
